// File: rtl/cnt_sequencer.sv
// cnt_sequencer: command-driven up/down counter sequencer with prescaler, pause, abort and auto-reload
module cnt_sequencer #(
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_down,
    input  logic             cmd_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [PW-1:0]    psc;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] limit_q;
    logic             down_q;
    logic             reload_q;
    logic             tick;

    assign tick = (psc == PW'(PRESCALE - 1));

    // Sequencer FSM: accepts commands in IDLE, steps the count on prescaler ticks in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
            psc       <= '0;
            start_q   <= '0;
            limit_q   <= '0;
            down_q    <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        start_q   <= cmd_start;
                        limit_q   <= cmd_limit;
                        down_q    <= cmd_down;
                        reload_q  <= cmd_reload;
                        cnt       <= cmd_start;
                        psc       <= '0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (!pause) begin
                        if (tick) begin
                            psc <= '0;
                            if (cnt == limit_q) begin
                                done <= 1'b1;
                                if (reload_q) begin
                                    cnt <= start_q;
                                end else begin
                                    state     <= IDLE;
                                    busy      <= 1'b0;
                                    cmd_ready <= 1'b1;
                                end
                            end else begin
                                cnt <= down_q ? cnt - 1'b1 : cnt + 1'b1;
                            end
                        end else begin
                            psc <= psc + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_sequencer.sv
// tb_cnt_sequencer: directed tests of cnt_sequencer with prescale 1, 2 and 3 instances
module tb_cnt_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_start = '0;
    logic [2:0] cmd_limit = '0;
    logic       cmd_down = 1'b0;
    logic       cmd_reload = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] cnt1, cnt2, cnt3;
    logic       busy1, busy2, busy3;
    logic       done1, done2, done3;
    logic       rdy1, rdy2, rdy3;
    int         vectors = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    cnt_sequencer #(.WIDTH(3), .PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_start(cmd_start), .cmd_limit(cmd_limit), .cmd_down(cmd_down),
        .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
        .cnt(cnt1), .busy(busy1), .done(done1)
    );
    cnt_sequencer #(.WIDTH(3), .PRESCALE(2)) u2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .cmd_start(cmd_start), .cmd_limit(cmd_limit), .cmd_down(cmd_down),
        .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
        .cnt(cnt2), .busy(busy2), .done(done2)
    );
    cnt_sequencer #(.WIDTH(3), .PRESCALE(3)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_start(cmd_start), .cmd_limit(cmd_limit), .cmd_down(cmd_down),
        .cmd_reload(cmd_reload), .pause(pause), .abort(abort),
        .cnt(cnt3), .busy(busy3), .done(done3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [2:0] s, input logic [2:0] l, input logic d, input logic r);
        cmd_start = s;
        cmd_limit = l;
        cmd_down = d;
        cmd_reload = r;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_p1 cnt/busy/rdy/done got %0d/%b/%b/%b exp 0/0/1/0", cnt1, busy1, rdy1, done1);
        end
        vectors++;
        if ({cnt3, busy3, rdy3, done3} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_p3 cnt/busy/rdy/done got %0d/%b/%b/%b exp 0/0/1/0", cnt3, busy3, rdy3, done3);
        end
    endtask

    task automatic test_up();
        do_reset();
        issue(3'd0, 3'd3, 1'b0, 1'b0);
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL up_accept cnt/busy/rdy/done got %0d/%b/%b/%b exp 0/1/0/0", cnt1, busy1, rdy1, done1);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if ({cnt1, busy1, done1} !== {3'(i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL up_step%0d cnt/busy/done got %0d/%b/%b exp %0d/1/0", i, cnt1, busy1, done1, i);
            end
        end
        step();
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd3, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL up_done cnt/busy/rdy/done got %0d/%b/%b/%b exp 3/0/1/1", cnt1, busy1, rdy1, done1);
        end
        step();
        vectors++;
        if ({cnt1, busy1, done1} !== {3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL up_after cnt/busy/done got %0d/%b/%b exp 3/0/0", cnt1, busy1, done1);
        end
    endtask

    task automatic test_down_wrap();
        logic [2:0] seq [4];
        seq = '{3'd1, 3'd0, 3'd7, 3'd6};
        do_reset();
        issue(3'd1, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            vectors++;
            if ({cnt2, busy2, done2} !== {seq[i/2], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL down_k+%0d cnt/busy/done got %0d/%b/%b exp %0d/1/0", i, cnt2, busy2, done2, seq[i/2]);
            end
        end
        step();
        vectors++;
        if ({cnt2, busy2, rdy2, done2} !== {3'd6, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL down_done cnt/busy/rdy/done got %0d/%b/%b/%b exp 6/0/1/1", cnt2, busy2, rdy2, done2);
        end
    endtask

    task automatic test_reload();
        do_reset();
        issue(3'd5, 3'd7, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        cmd_start = 3'd0;
        cmd_reload = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            vectors++;
            if ({cnt1, busy1, rdy1, done1} !== {3'(5 + (i % 3)), 1'b1, 1'b0, 1'(i % 3 == 0)}) begin
                errors++;
                $display("FAIL reload_k+%0d cnt/busy/rdy/done got %0d/%b/%b/%b exp %0d/1/0/%0d",
                         i, cnt1, busy1, rdy1, done1, 5 + (i % 3), i % 3 == 0);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_pause_abort();
        logic [2:0] exp;
        do_reset();
        issue(3'd0, 3'd7, 1'b0, 1'b0);
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({cnt1, busy1, done1} !== {3'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d cnt/busy/done got %0d/%b/%b exp 2/1/0", i, cnt1, busy1, done1);
            end
        end
        pause = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            step();
            exp = 3'(i);
            vectors++;
            if ({cnt1, busy1} !== {exp, 1'b1}) begin
                errors++;
                $display("FAIL pause_resume cnt/busy got %0d/%b exp %0d/1", cnt1, busy1, exp);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd5, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_idle cnt/busy/rdy/done got %0d/%b/%b/%b exp 5/0/1/0", cnt1, busy1, rdy1, done1);
        end
        step();
        step();
        vectors++;
        if ({cnt1, busy1, done1} !== {3'd5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_stays cnt/busy/done got %0d/%b/%b exp 5/0/0", cnt1, busy1, done1);
        end
    endtask

    task automatic test_same_limit();
        do_reset();
        issue(3'd4, 3'd4, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step();
            vectors++;
            if ({cnt3, busy3, done3} !== {3'd4, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL same_k+%0d cnt/busy/done got %0d/%b/%b exp 4/1/0", i, cnt3, busy3, done3);
            end
        end
        step();
        vectors++;
        if ({cnt3, busy3, rdy3, done3} !== {3'd4, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL same_done cnt/busy/rdy/done got %0d/%b/%b/%b exp 4/0/1/1", cnt3, busy3, rdy3, done3);
        end
    endtask

    task automatic test_abort_terminal();
        do_reset();
        issue(3'd2, 3'd3, 1'b0, 1'b0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd3, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_term cnt/busy/rdy/done got %0d/%b/%b/%b exp 3/0/1/0", cnt1, busy1, rdy1, done1);
        end
        step();
        vectors++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_term_late done got %b exp 0", done1);
        end
    endtask

    task automatic test_rst_midrun();
        do_reset();
        issue(3'd0, 3'd7, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid cnt/busy/rdy/done got %0d/%b/%b/%b exp 0/0/1/0", cnt1, busy1, rdy1, done1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(3'd6, 3'd7, 1'b0, 1'b0);
        step();
        step();
        vectors++;
        if ({busy1, rdy1, done1} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_done busy/rdy/done got %b/%b/%b exp 0/1/1", busy1, rdy1, done1);
        end
        issue(3'd1, 3'd1, 1'b1, 1'b0);
        vectors++;
        if ({cnt1, busy1, rdy1, done1} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_accept cnt/busy/rdy/done got %0d/%b/%b/%b exp 1/1/0/0", cnt1, busy1, rdy1, done1);
        end
        step();
        vectors++;
        if ({cnt1, busy1, done1} !== {3'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second cnt/busy/done got %0d/%b/%b exp 1/0/1", cnt1, busy1, done1);
        end
        step();
        issue(3'd3, 3'd3, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if ({cnt1, busy1, done1} !== {3'd3, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reload_d0_%0d cnt/busy/done got %0d/%b/%b exp 3/1/1", i, cnt1, busy1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_reload();
        test_pause_abort();
        test_same_limit();
        test_abort_terminal();
        test_rst_midrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Command-driven controller that sequences the design's small up/down counter datapath. A requester loads a start value, a terminal value, a direction and a reload mode through a valid/ready handshake. The block then steps the counter once per prescaler tick until it reaches the terminal value, reports completion with a one-cycle `done` pulse, and either re-arms or returns to idle. It sits between control logic or software-facing registers and the counter output `cnt`, which feeds the downstream display and test logic.

## Interface
- `WIDTH`, 3: counter width in bits.
- `PRESCALE`, 1: clock cycles per count step; legal range is ≥1.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  requester presents a command.
- `cmd_ready`  out  1  block accepts a command; high only in IDLE.
- `cmd_start`  in  WIDTH  initial count value.
- `cmd_limit`  in  WIDTH  terminal count value.
- `cmd_down`  in  1  1 selects count down, 0 selects count up.
- `cmd_reload`  in  1  1 selects auto-reload to `cmd_start` after terminal; 0 selects one-shot.
- `pause`  in  1  freezes the count and the prescaler while high.
- `abort`  in  1  terminates a run with no `done`.
- `cnt`  out  WIDTH  current count (registered).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a terminal tick is taken.

## Operation
- States:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - RUN: `cmd_ready`=0, `busy`=1.
- IDLE → RUN on `cmd_valid & cmd_ready`:
  - latch start, limit, down and reload;
  - load `cnt` ← `cmd_start`;
  - clear the prescaler.
- RUN, each cycle, in priority order:
  1. `abort`: go to IDLE; `cnt` holds; `done` stays 0.
  2. `pause`: prescaler and `cnt` hold.
  3. Otherwise the prescaler increments. A tick occurs when the prescaler equals `PRESCALE-1`; the prescaler then returns to 0.
- On a tick:
  - If `cnt == limit`:
    - assert `done` for the next cycle;
    - if reload, load `cnt` ← start and stay in RUN;
    - otherwise go to IDLE and hold `cnt` at limit.
  - Otherwise `cnt` ← `cnt ± 1` modulo 2^WIDTH. Wrap-around is legal: up 7→0 and down 0→7 for WIDTH=3.
- Distance is `(limit-start) mod 2^WIDTH` when counting up, or `(start-limit) mod 2^WIDTH` when counting down.
- Ticks per pass equal distance+1. When start==limit, the first tick produces `done` and `cnt` never changes.
- `cmd_valid` outside IDLE is ignored and nothing is latched. Command inputs need only be stable in the accepting cycle.
- `abort` and `pause` have no effect in IDLE. `pause` is sampled from the first RUN cycle onward.
- `rst` at any time, including mid-run, forces reset values on the next edge. No `done` is produced.

## Timing
- Reset values:
  - state IDLE;
  - `cnt`=0, `busy`=0, `done`=0, `cmd_ready`=1;
  - prescaler and latched config = 0.
- Command accepted at edge k: from after edge k, `cnt`=start, `busy`=1 and `cmd_ready`=0.
- With `PRESCALE`=P and no pause, the terminal tick is taken at edge k + (distance+1)·P.
- After that edge:
  - `done`=1 for exactly one cycle;
  - for one-shot, `busy`=0 and `cmd_ready`=1 in the same cycle. A new command can be accepted at the following edge (at the earliest, the edge after the terminal tick).
- Pause cycles extend the latency one for one. Releasing `pause` resumes from the frozen prescaler value.
- Abort asserted before edge j: from after edge j, IDLE and `cmd_ready`=1. If a terminal tick coincides with edge j, it is discarded.
- In reload mode, consecutive `done` pulses are spaced (distance+1)·P cycles apart.
- `done` never stays high for two consecutive cycles unless distance=0 and P=1 in reload mode. In that case `done` is continuously high.

## Test plan
- Reset then up-count: `rst` for 2 cycles, then command start=0, limit=3, up, one-shot, P=1 at edge k → `cnt` 0,1,2,3 after edges k..k+3; `done`=1 only after k+4; `busy` falls with `done`; `cnt` holds 3.
- Down with wrap: start=1, limit=6, down, P=2 → `cnt` sequence 1,0,7,6, each value held 2 cycles; `done` after edge k+8.
- Reload: start=5, limit=7, up, reload, P=1 → `cnt` 5,6,7,5,6,7…; `done` pulses every 3 cycles; `busy` stays 1; `cmd_valid` during the run is not accepted.
- Pause and abort: start=0, limit=7, up; `pause` for 4 cycles at `cnt`=2 → `cnt` holds 2, with latency +4. Then `abort` at `cnt`=5 → IDLE next cycle, `cnt`=5, no `done`.
- Boundaries:
  - start==limit=4, P=3 → `done` after edge k+3 and `cnt` stays 4;
  - `abort` on the terminal-tick edge → no `done`;
  - `rst` mid-run → `cnt`=0, `busy`=0, `cmd_ready`=1.
